// File: rtl/sevenseg_scan_driver.sv
// Multiplexed common-anode seven-segment scan driver with per-frame snapshot.
// Optional leading-zero blanking is built when SEVENSEG_LZB_EN is defined.
module sevenseg_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int HEX_MODE     = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] val_snap;
  logic [NUM_DIGITS-1:0]   dp_snap;
  logic [NUM_DIGITS-1:0]   en_snap;
  logic                    cnt_wrap;
  logic                    frame_wrap;

  logic [3:0]              cur_nib;
  logic                    cur_en;
  logic                    cur_dp;
  logic                    cur_lzb;
  logic                    lit;
  logic [NUM_DIGITS-1:0]   an_next;
  logic [6:0]              seg_next;
  logic                    dp_next;

  assign cnt_wrap   = (cnt == CNT_LAST);
  assign frame_wrap = cnt_wrap && (idx == IDX_LAST);

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    s = 7'h7F;
    case (n)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      default: s = 7'h7F;
    endcase
    if (HEX_MODE != 0) begin
      case (n)
        4'hA: s = 7'b0001000;
        4'hB: s = 7'b1100000;
        4'hC: s = 7'b0110001;
        4'hD: s = 7'b1000010;
        4'hE: s = 7'b0110000;
        4'hF: s = 7'b0111000;
        default: ;
      endcase
    end
    return s;
  endfunction

  // slot counter, digit index and whole-frame snapshot of the inputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= CNT_LAST;
      idx         <= IDX_LAST;
      val_snap    <= '0;
      dp_snap     <= '0;
      en_snap     <= '0;
      frame_start <= 1'b0;
    end else begin
      cnt         <= cnt_wrap ? '0 : cnt + 1'b1;
      frame_start <= frame_wrap;
      if (cnt_wrap) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
      if (frame_wrap) begin
        val_snap <= value;
        dp_snap  <= dp_in;
        en_snap  <= digit_en;
      end
    end
  end

`ifdef SEVENSEG_LZB_EN
  logic [NUM_DIGITS-1:0] zero_above;

  // digit i has itself and every higher digit equal to zero
  always_comb begin
    logic z;
    z = 1'b1;
    zero_above = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      z = z & (val_snap[4*i +: 4] == 4'h0);
      zero_above[i] = z;
    end
  end
`endif

  // select the snapshot fields of the digit being scanned
  always_comb begin
    cur_nib = '0;
    cur_en  = 1'b0;
    cur_dp  = 1'b0;
    cur_lzb = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib = val_snap[4*i +: 4];
        cur_en  = en_snap[i];
        cur_dp  = dp_snap[i];
`ifdef SEVENSEG_LZB_EN
        cur_lzb = (i != 0) && zero_above[i];
`endif
      end
    end
  end

  // next output values: dark during blanking or when the digit is disabled
  always_comb begin
    lit      = cur_en && (cnt >= BLANK_END);
    an_next  = '1;
    seg_next = 7'h7F;
    dp_next  = 1'b1;
    if (lit) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        an_next[i] = (idx != IW'(i));
      end
      seg_next = cur_lzb ? 7'h7F : decode(cur_nib);
      dp_next  = ~cur_dp;
    end
  end

  // registered pin drivers, forced dark by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= '1;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Bench for sevenseg_scan_driver: vector table, corner sequences and a
// frame-level reference model checked every cycle (decimal and hex builds).
module tb_sevenseg_scan_driver;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BL = 2;
  localparam int FR = ND * RD;

  localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010, S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100, S5 = 7'b0100100;
  localparam logic [6:0] S6 = 7'b0100000, S7 = 7'b0001111;
  localparam logic [6:0] S8 = 7'b0000000, S9 = 7'b0000100;
  localparam logic [6:0] SA = 7'b0001000, SB = 7'b1100000;
  localparam logic [6:0] SC = 7'b0110001, SD = 7'b1000010;
  localparam logic [6:0] SE = 7'b0110000, SF = 7'b0111000;
  localparam logic [6:0] BK = 7'h7F;
`ifdef SEVENSEG_LZB_EN
  localparam logic [6:0] LZ = BK;
`else
  localparam logic [6:0] LZ = S0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] value = '0;
  logic [3:0] dp_in = '0;
  logic [3:0] digit_en = '0;
  logic [6:0] seg0, seg1;
  logic dp0, dp1, fs0, fs1;
  logic [3:0] an0, an1;

  int n_tests = 0;
  int n_fail = 0;
  int k = 0;

  typedef struct packed {
    logic [15:0] v;
    logic [3:0] dpi;
    logic [3:0] en;
  } snap_t;
  snap_t snaps[$];

  typedef struct packed {
    logic [15:0] v;
    logic [3:0] dpi;
    logic [3:0] en;
    logic [27:0] s0;
    logic [27:0] s1;
  } vec_t;
  vec_t tbl[7];

  always #5 clk = ~clk;

  sevenseg_scan_driver #(
    .NUM_DIGITS(ND), .REFRESH_DIV(RD),
    .BLANK_CYCLES(BL), .HEX_MODE(0)
  ) u_dec (
    .clk(clk), .reset(reset), .value(value),
    .dp_in(dp_in), .digit_en(digit_en),
    .seg(seg0), .dp(dp0), .an(an0),
    .frame_start(fs0)
  );

  sevenseg_scan_driver #(
    .NUM_DIGITS(ND), .REFRESH_DIV(RD),
    .BLANK_CYCLES(BL), .HEX_MODE(1)
  ) u_hex (
    .clk(clk), .reset(reset), .value(value),
    .dp_in(dp_in), .digit_en(digit_en),
    .seg(seg1), .dp(dp1), .an(an1),
    .frame_start(fs1)
  );

  function automatic logic [6:0] ref_seg(input logic [3:0] n,
                                         input bit hex);
    logic [6:0] dt[10];
    logic [6:0] ht[6];
    dt = '{S0, S1, S2, S3, S4, S5, S6, S7, S8, S9};
    ht = '{SA, SB, SC, SD, SE, SF};
    if (n < 10) return dt[n];
    if (hex) return ht[n - 10];
    return BK;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 20)
        $display("FAIL %s: got %h expected %h at k=%0d t=%0t",
                 name, act, exp, k, $time);
    end
  endtask

  // edge count since reset release; a snapshot is recorded per frame
  always @(posedge clk) begin
    if (reset) begin
      k = 0;
      snaps.delete();
    end else begin
      k = k + 1;
      if ((k - 1) % FR == 0) snaps.push_back({value, dp_in, digit_en});
    end
  end

  // per-cycle reference: position in the scan derived from the edge count
  always @(negedge clk) begin
    logic [3:0] ea;
    logic [6:0] es0, es1;
    logic ed, ef;
    int pos, f, d, off;
    snap_t s;
    bit lz;
    ea = 4'hF; es0 = BK; es1 = BK; ed = 1'b1; ef = 1'b0;
    if (!reset && k >= 1) begin
      ef = ((k - 1) % FR == 0);
      if (k >= 2) begin
        pos = k - 2;
        f = pos / FR;
        d = (pos % FR) / RD;
        off = pos % RD;
        s = (f < snaps.size()) ? snaps[f] : '0;
        if (off >= BL && s.en[d]) begin
          lz = 1'b0;
`ifdef SEVENSEG_LZB_EN
          lz = (d > 0) && ((s.v >> (4 * d)) == 0);
`endif
          ea[d] = 1'b0;
          es0 = lz ? BK : ref_seg(s.v[4*d +: 4], 1'b0);
          es1 = lz ? BK : ref_seg(s.v[4*d +: 4], 1'b1);
          ed = ~s.dpi[d];
        end
      end
    end
    check("model", {6'b0, an0, an1, seg0, seg1, dp0, dp1, fs0, fs1},
          {6'b0, ea, ea, es0, es1, ed, ed, ef, ef});
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_k(input int target);
    int n;
    n = 0;
    @(negedge clk);
    while (k != target && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (k != target) check("wait_timeout", k, target);
  endtask

  task automatic do_reset(input logic [15:0] v, input logic [3:0] dpi,
                          input logic [3:0] en);
    step();
    reset = 1'b1;
    step();
    step();
    value = v;
    dp_in = dpi;
    digit_en = en;
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] ea;
    logic [6:0] e0, e1;
    logic ed;
    tbl[0] = {16'h1234, 4'h0, 4'hF, {S1, S2, S3, S4}, {S1, S2, S3, S4}};
    tbl[1] = {16'h5678, 4'h0, 4'hF, {S5, S6, S7, S8}, {S5, S6, S7, S8}};
    tbl[2] = {16'h00AF, 4'h0, 4'hF, {LZ, LZ, BK, BK}, {LZ, LZ, SA, SF}};
    tbl[3] = {16'h7777, 4'b0100, 4'b1011,
              {S7, S7, S7, S7}, {S7, S7, S7, S7}};
    tbl[4] = {16'h0040, 4'h0, 4'hF, {LZ, LZ, S4, S0}, {LZ, LZ, S4, S0}};
    tbl[5] = {16'h0000, 4'hF, 4'hF, {LZ, LZ, LZ, S0}, {LZ, LZ, LZ, S0}};
    tbl[6] = {16'hDCB9, 4'b1010, 4'hF,
              {BK, BK, BK, S9}, {SD, SC, SB, S9}};

    step();
    check("reset_state", {21'b0, an0, seg0, dp0, fs0}, {21'b0, 4'hF, BK, 1'b1, 1'b0});

    // vector table: one frame per entry, middle of each digit's lit window
    for (int t = 0; t < 7; t++) begin
      do_reset(tbl[t].v, tbl[t].dpi, tbl[t].en);
      for (int d = 0; d < ND; d++) begin
        wait_k(d * RD + 6);
        ea = 4'hF;
        e0 = BK;
        e1 = BK;
        ed = 1'b1;
        if (tbl[t].en[d]) begin
          ea[d] = 1'b0;
          e0 = tbl[t].s0[7*d +: 7];
          e1 = tbl[t].s1[7*d +: 7];
          ed = ~tbl[t].dpi[d];
        end
        check($sformatf("vec%0d_dig%0d", t, d),
              {13'b0, an0, seg0, seg1, ed == dp0},
              {13'b0, ea, e0, e1, 1'b1});
      end
    end

    // frame_start timing and 32-cycle repetition
    do_reset(16'h1234, 4'h0, 4'hF);
    wait_k(1);
    check("fs_first", fs0, 1);
    wait_k(2);
    check("fs_low", fs0, 0);
    wait_k(2 + BL - 1);
    check("blank_an", an0, 4'hF);
    wait_k(33);
    check("fs_repeat", fs0, 1);
    wait_k(32 + 6);
    check("repeat_dig0", {an0, seg0}, {4'b1110, S4});

    // mid-frame change: current frame unaffected, next frame updated
    do_reset(16'h1234, 4'h0, 4'hF);
    wait_k(10);
    value = 16'h5678;
    wait_k(3 * RD + 6);
    check("no_tear", {an0, seg0}, {4'b0111, S1});
    wait_k(FR + 6);
    check("next_frame", {an0, seg0}, {4'b1110, S8});

    // async reset while digit 2 is lit
    do_reset(16'h1234, 4'h4, 4'hF);
    wait_k(2 * RD + 6);
    check("pre_rst_lit", {an0, seg0, dp0}, {4'b1011, S2, 1'b0});
    #1 reset = 1'b1;
    #1 check("async_dark", {an0, seg0, dp0}, {4'hF, BK, 1'b1});
    step();
    reset = 1'b0;
    wait_k(1);
    check("fs_after_rst", fs0, 1);

    // randomized inputs against the frame model
    do_reset(16'($urandom), 4'($urandom), 4'($urandom));
    for (int i = 0; i < 800; i++) begin
      step();
      if ($urandom_range(0, 9) == 0) value = 16'($urandom);
      if ($urandom_range(0, 9) == 0) dp_in = 4'($urandom);
      if ($urandom_range(0, 9) == 0) digit_en = 4'($urandom);
      if ($urandom_range(0, 15) == 0) value = 16'($urandom_range(0, 255));
      if (i == 400) reset = 1'b1;
      if (i == 402) reset = 1'b0;
    end
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
